atomic_counter_bank: RTL and testbench

Bank of `NUM_CH` parametrised event counters (`CNT_W` bits each), read over a narrow `BUS_W`-bit request/acknowledge bus with single-copy-atomic multi-word reads. This is the next generation of the single 64-bit atomic event counter: it generalises channel count, counter width and bus width, and adds clear, load, saturate mode, sticky overflow and protocol-error reporting. It sits between the SoC event sources and the microcontroller-facing register bus.

---
 rtl/atomic_cnt_pkg.sv | 24 ++
 rtl/event_counter.sv | 70 +++++++
 rtl/atomic_counter_bank.sv | 168 ++++++++++++++++
 tb/tb_atomic_counter_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atomic_cnt_pkg.sv
// -----------------------------------------------------------------------------
// atomic_cnt_pkg
// Shared definitions for the atomic counter bank: default parameter values,
// the read FSM state type and a helper that sizes index fields safely.
// -----------------------------------------------------------------------------
package atomic_cnt_pkg;

    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_CNT_W    = 64;
    localparam int unsigned DEF_BUS_W    = 32;
    localparam int unsigned DEF_SATURATE = 0;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    // Width of an index field able to address n items; never narrower than
    // one bit, so a single-entry bank still has a legal select port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/event_counter.sv
// -----------------------------------------------------------------------------
// event_counter
// One counter channel with synchronous clear, load and increment.
// Priority is clear > load > increment > hold. An increment from all-ones
// wraps to zero (SATURATE=0) or holds (SATURATE=1). Either way it sets the
// sticky overflow flag, which only clear or reset can drop.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   clr_i     in   clear counter and overflow flag
//   ld_i      in   load ld_val_i into the counter (overflow flag untouched)
//   ld_val_i  in   load value
//   trig_i    in   increment by one
//   cnt_o     out  registered counter value
//   ovf_o     out  sticky overflow flag
// -----------------------------------------------------------------------------
module event_counter #(
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    input  logic             trig_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (clr_i) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (ld_i) begin
            w_cnt_nxt = ld_val_i;
        end else if (trig_i) begin
            if (&r_cnt) begin
                w_ovf_nxt = 1'b1;
                if (SATURATE == 0) begin
                    w_cnt_nxt = '0;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign cnt_o = r_cnt;
    assign ovf_o = r_ovf;

endmodule

// File: rtl/atomic_counter_bank.sv
// -----------------------------------------------------------------------------
// atomic_counter_bank
// NUM_CH event counters read over a BUS_W-bit request/acknowledge bus.
// An atomic request snapshots a whole counter and returns its low word; the
// following plain requests to the same channel return the remaining words of
// that snapshot, so a multi-word read is never torn by concurrent updates.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset, clears all state
//   trig_i    in   per-channel increment strobe
//   clr_i     in   per-channel clear (counter and overflow flag)
//   ld_i      in   load strobe
//   ld_ch_i   in   channel written by ld_i
//   ld_val_i  in   value written by ld_i
//   req_i     in   read request
//   atomic_i  in   request starts a new read sequence
//   ch_sel_i  in   channel addressed by the request
//   ack_o     out  read acknowledge, req_i delayed one cycle
//   count_o   out  read data, holds between acks
//   err_o     out  protocol error, only together with ack_o
//   ovf_o     out  sticky per-channel overflow flags
// -----------------------------------------------------------------------------
module atomic_counter_bank
    import atomic_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned BUS_W    = DEF_BUS_W,
    parameter int unsigned SATURATE = DEF_SATURATE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            trig_i,
    input  logic [NUM_CH-1:0]            clr_i,
    input  logic                         ld_i,
    input  logic [idx_width(NUM_CH)-1:0] ld_ch_i,
    input  logic [CNT_W-1:0]             ld_val_i,
    input  logic                         req_i,
    input  logic                         atomic_i,
    input  logic [idx_width(NUM_CH)-1:0] ch_sel_i,
    output logic                         ack_o,
    output logic [BUS_W-1:0]             count_o,
    output logic                         err_o,
    output logic [NUM_CH-1:0]            ovf_o
);

    localparam int unsigned WORDS  = CNT_W / BUS_W;
    localparam int unsigned CH_W   = idx_width(NUM_CH);
    localparam int unsigned WIDX_W = idx_width(WORDS);

    // Counter channels
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_ovf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        event_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clr_i    (clr_i[g]),
            .ld_i     (ld_i && (ld_ch_i == CH_W'(g))),
            .ld_val_i (ld_val_i),
            .trig_i   (trig_i[g]),
            .cnt_o    (w_cnt[g]),
            .ovf_o    (w_ovf[g])
        );
    end

    assign ovf_o = w_ovf;

    // Read path state
    rd_state_t         r_state;
    logic [CNT_W-1:0]  r_snap;
    logic [CH_W-1:0]   r_snap_ch;
    logic [WIDX_W-1:0] r_widx;
    logic              r_ack;
    logic [BUS_W-1:0]  r_count;
    logic              r_err;

    rd_state_t         w_state_nxt;
    logic [CNT_W-1:0]  w_snap_nxt;
    logic [CH_W-1:0]   w_snap_ch_nxt;
    logic [WIDX_W-1:0] w_widx_nxt;
    logic [BUS_W-1:0]  w_count_nxt;
    logic              w_err_nxt;

    logic [CNT_W-1:0]  w_sel_cnt;
    logic [BUS_W-1:0]  w_word;

    // Pre-update value of the addressed counter; unpopulated selects read 0.
    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_i == CH_W'(i)) begin
                w_sel_cnt = w_cnt[i];
            end
        end
    end

    // Word widx of the snapshot.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_widx == WIDX_W'(i)) begin
                w_word = r_snap[i*BUS_W +: BUS_W];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_snap_nxt    = r_snap;
        w_snap_ch_nxt = r_snap_ch;
        w_widx_nxt    = r_widx;
        w_count_nxt   = r_count;
        w_err_nxt     = 1'b0;
        if (req_i) begin
            if (atomic_i) begin
                // Restarts from any state, abandoning an unfinished sequence.
                w_snap_nxt    = w_sel_cnt;
                w_snap_ch_nxt = ch_sel_i;
                w_count_nxt   = w_sel_cnt[BUS_W-1:0];
                w_widx_nxt    = WIDX_W'(1);
                w_state_nxt   = RD_BURST;
            end else if ((r_state == RD_BURST) && (ch_sel_i == r_snap_ch)) begin
                w_count_nxt = w_word;
                if (r_widx == WIDX_W'(WORDS - 1)) begin
                    w_widx_nxt  = '0;
                    w_state_nxt = RD_IDLE;
                end else begin
                    w_widx_nxt = r_widx + WIDX_W'(1);
                end
            end else begin
                // Out-of-sequence read: report it, keep the sequence intact.
                w_count_nxt = '0;
                w_err_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RD_IDLE;
            r_snap    <= '0;
            r_snap_ch <= '0;
            r_widx    <= '0;
            r_ack     <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_snap    <= w_snap_nxt;
            r_snap_ch <= w_snap_ch_nxt;
            r_widx    <= w_widx_nxt;
            r_ack     <= req_i;
            r_count   <= w_count_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign ack_o   = r_ack;
    assign count_o = r_count;
    assign err_o   = r_err;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_atomic_counter_bank
// Three banks share one stimulus stream: default (wrap), SATURATE=1, and a
// 128-bit counter / 32-bit bus build. Each read pushes the expected ack word
// of every bank to its queue; the queues are drained one cycle later.
// -----------------------------------------------------------------------------
module tb_atomic_counter_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   trig;
    logic [3:0]   clr;
    logic         ld;
    logic [1:0]   ld_ch;
    logic [127:0] ld_val;
    logic         req;
    logic         atomic;
    logic [1:0]   ch_sel;

    logic        ack_m, err_m, ack_s, err_s, ack_w, err_w;
    logic [31:0] cnt_m, cnt_s, cnt_w;
    logic [3:0]  ovf_m, ovf_s, ovf_w;

    always #5 clk = ~clk;

    atomic_counter_bank u_main (
        .clk(clk), .reset(reset), .trig_i(trig), .clr_i(clr), .ld_i(ld), .ld_ch_i(ld_ch),
        .ld_val_i(ld_val[63:0]), .req_i(req), .atomic_i(atomic), .ch_sel_i(ch_sel),
        .ack_o(ack_m), .count_o(cnt_m), .err_o(err_m), .ovf_o(ovf_m)
    );

    atomic_counter_bank #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .trig_i(trig), .clr_i(clr), .ld_i(ld), .ld_ch_i(ld_ch),
        .ld_val_i(ld_val[63:0]), .req_i(req), .atomic_i(atomic), .ch_sel_i(ch_sel),
        .ack_o(ack_s), .count_o(cnt_s), .err_o(err_s), .ovf_o(ovf_s)
    );

    atomic_counter_bank #(.CNT_W(128), .BUS_W(32)) u_wide (
        .clk(clk), .reset(reset), .trig_i(trig), .clr_i(clr), .ld_i(ld), .ld_ch_i(ld_ch),
        .ld_val_i(ld_val), .req_i(req), .atomic_i(atomic), .ch_sel_i(ch_sel),
        .ack_o(ack_w), .count_o(cnt_w), .err_o(err_w), .ovf_o(ovf_w)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_w[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_port(input string name, input logic ack, input logic [31:0] cnt,
                              input logic err, input bit have, input exp_t e);
        if (have) begin
            check_eq({name, ".ack"}, ack, 1'b1);
            if (e.chk) begin
                check_eq({name, ".count"}, cnt, e.cnt);
                check_eq({name, ".err"}, err, e.err);
            end
        end else begin
            check_eq({name, ".noack"}, ack, 1'b0);
            check_eq({name, ".noerr"}, err, 1'b0);
        end
    endtask

    // Advance one cycle, check every bank's ack against its queue, then drop
    // the one-shot strobes. trig is left for the caller to manage.
    task automatic tick();
        exp_t e;
        bit   have;
        @(posedge clk);
        #1;
        have = (q_m.size() > 0);
        e    = have ? q_m.pop_front() : '0;
        check_port("main", ack_m, cnt_m, err_m, have, e);
        have = (q_s.size() > 0);
        e    = have ? q_s.pop_front() : '0;
        check_port("sat", ack_s, cnt_s, err_s, have, e);
        have = (q_w.size() > 0);
        e    = have ? q_w.pop_front() : '0;
        check_port("wide", ack_w, cnt_w, err_w, have, e);
        req    = 1'b0;
        atomic = 1'b0;
        ld     = 1'b0;
        clr    = '0;
    endtask

    task automatic rd(input logic at, input logic [1:0] ch,
                      input logic [31:0] mc, input logic me,
                      input logic [31:0] sc, input logic se,
                      input logic wchk, input logic [31:0] wc, input logic we);
        req    = 1'b1;
        atomic = at;
        ch_sel = ch;
        q_m.push_back('{chk: 1'b1, cnt: mc, err: me});
        q_s.push_back('{chk: 1'b1, cnt: sc, err: se});
        q_w.push_back('{chk: wchk, cnt: wc, err: we});
    endtask

    task automatic rd3(input logic at, input logic [1:0] ch, input logic [31:0] c,
                       input logic e);
        rd(at, ch, c, e, c, e, 1'b1, c, e);
    endtask

    initial begin
        reset  = 1'b1;
        trig   = '0;
        clr    = '0;
        ld     = 1'b0;
        ld_ch  = '0;
        ld_val = '0;
        req    = 1'b0;
        atomic = 1'b0;
        ch_sel = '0;
        tick();
        check_eq("rst.count_main", cnt_m, 32'h0);
        check_eq("rst.count_wide", cnt_w, 32'h0);
        check_eq("rst.ovf_main", ovf_m, 4'h0);
        check_eq("rst.ovf_sat", ovf_s, 4'h0);
        reset = 1'b0;
        tick();

        // Carry between words must not tear the snapshot.
        ld = 1'b1; ld_ch = 2'd0; ld_val = 128'h0000_0000_FFFF_FFFF; trig = 4'b0001;
        tick();
        rd3(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        rd3(1'b0, 2'd0, 32'h0000_0000, 1'b0);
        tick();
        trig = '0;

        // Wrap vs saturate from all-ones.
        ld = 1'b1; ld_ch = 2'd0; ld_val = {64'h0, {64{1'b1}}};
        tick();
        trig = 4'b0001;
        tick();
        trig = '0;
        check_eq("wrap.ovf_main", ovf_m, 4'b0001);
        check_eq("sat.ovf_sat", ovf_s, 4'b0001);
        check_eq("wide.ovf_none", ovf_w, 4'b0000);
        rd(1'b1, 2'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        rd(1'b0, 2'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        clr = 4'b0001;
        tick();
        check_eq("clr.ovf_main", ovf_m, 4'b0000);
        check_eq("clr.ovf_sat", ovf_s, 4'b0000);
        rd3(1'b1, 2'd0, 32'h0, 1'b0);
        tick();
        rd3(1'b0, 2'd0, 32'h0, 1'b0);
        tick();

        // Back-to-back reads on two channels.
        ld = 1'b1; ld_ch = 2'd1; ld_val = 128'h1111_2222_3333_4444;
        tick();
        ld = 1'b1; ld_ch = 2'd2; ld_val = 128'h5555_6666_7777_8888;
        tick();
        rd3(1'b1, 2'd1, 32'h3333_4444, 1'b0);
        tick();
        rd3(1'b0, 2'd1, 32'h1111_2222, 1'b0);
        tick();
        rd3(1'b1, 2'd2, 32'h7777_8888, 1'b0);
        tick();
        rd3(1'b0, 2'd2, 32'h5555_6666, 1'b0);
        tick();

        // Protocol errors; updates on the snapshot channel leave snap alone.
        rd3(1'b0, 2'd0, 32'h0, 1'b1);
        tick();
        trig = 4'b0010;
        rd3(1'b1, 2'd1, 32'h3333_4444, 1'b0);
        tick();
        trig = '0;
        ld = 1'b1; ld_ch = 2'd1; ld_val = 128'hDEAD_BEEF_DEAD_BEEF;
        rd3(1'b0, 2'd3, 32'h0, 1'b1);
        tick();
        clr = 4'b0010;
        rd3(1'b0, 2'd1, 32'h1111_2222, 1'b0);
        tick();
        tick();
        check_eq("hold.count_main", cnt_m, 32'h1111_2222);
        check_eq("hold.count_wide", cnt_w, 32'h1111_2222);

        // Atomic restart picks up the newer value.
        ld = 1'b1; ld_ch = 2'd0; ld_val = 128'hAAAA_0001_AAAA_0002;
        tick();
        ld = 1'b1; ld_ch = 2'd0; ld_val = 128'hBBBB_0003_BBBB_0004;
        rd3(1'b1, 2'd0, 32'hAAAA_0002, 1'b0);
        tick();
        rd3(1'b1, 2'd0, 32'hBBBB_0004, 1'b0);
        tick();
        rd3(1'b0, 2'd0, 32'hBBBB_0003, 1'b0);
        tick();

        // Reset mid-burst aborts the sequence.
        rd3(1'b1, 2'd0, 32'hBBBB_0004, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check_eq("rst_mid.count_main", cnt_m, 32'h0);
        check_eq("rst_mid.ack_main", ack_m, 1'b0);
        tick();
        reset = 1'b0;
        rd3(1'b0, 2'd0, 32'h0, 1'b1);
        tick();
        rd3(1'b1, 2'd0, 32'h0, 1'b0);
        tick();
        rd3(1'b0, 2'd0, 32'h0, 1'b0);
        tick();

        // Four-word snapshot while trig toggles.
        ld = 1'b1; ld_ch = 2'd3; ld_val = 128'h0123_4567_89AB_CDEF_FEDC_BA98_FFFF_FFFE;
        tick();
        trig = 4'b1000;
        rd(1'b1, 2'd3, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        trig = '0;
        rd(1'b0, 2'd3, 32'hFEDC_BA98, 1'b0, 32'hFEDC_BA98, 1'b0, 1'b1, 32'hFEDC_BA98, 1'b0);
        tick();
        trig = 4'b1000;
        rd(1'b0, 2'd3, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h89AB_CDEF, 1'b0);
        tick();
        trig = '0;
        rd(1'b0, 2'd3, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0123_4567, 1'b0);
        tick();
        rd3(1'b0, 2'd3, 32'h0, 1'b1);
        tick();
        // Both increments landed in the live counter.
        rd3(1'b1, 2'd3, 32'h0000_0000, 1'b0);
        tick();
        rd3(1'b0, 2'd3, 32'hFEDC_BA99, 1'b0);
        tick();
        check_eq("end.ovf_wide", ovf_w, 4'b0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
